// File: rtl/ahb_apb_bridge_mp.sv
// AHB-Lite slave to APB3 master bridge with windowed one-hot slave decode, Pready wait states
// and a two-cycle AHB ERROR for bad address/size. Define AHB2APB_PSLVERR_EN to add the Pslverr input.
module ahb_apb_bridge_mp #(
    parameter int               WIDTH   = 32,
    parameter int               SLAVES  = 4,
    parameter int               SEL_LSB = 12,
    parameter logic [WIDTH-1:0] BASE    = WIDTH'(32'h8000_0000)
) (
    input  logic              Hclk,
    input  logic              Hreset,
    input  logic [1:0]        Htrans,
    input  logic [2:0]        Hsize,
    input  logic              Hreadyin,
    input  logic              Hwrite,
    input  logic [WIDTH-1:0]  Haddr,
    input  logic [WIDTH-1:0]  Hwdata,
    output logic [WIDTH-1:0]  Hrdata,
    output logic [1:0]        Hresp,
    output logic              Hreadyout,
    input  logic [WIDTH-1:0]  Prdata,
    input  logic              Pready,
`ifdef AHB2APB_PSLVERR_EN
    input  logic              Pslverr,
`endif
    output logic [SLAVES-1:0] Pselx,
    output logic              Penable,
    output logic              Pwrite,
    output logic [WIDTH-1:0]  Paddr,
    output logic [WIDTH-1:0]  Pwdata,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LATCH  = 3'd1,
        S_SETUP  = 3'd2,
        S_ACCESS = 3'd3,
        S_ERR1   = 3'd4,
        S_ERR2   = 3'd5
    } state_t;

    localparam logic [1:0]     RESP_OKAY  = 2'b00;
    localparam logic [1:0]     RESP_ERROR = 2'b01;
    localparam logic [2:0]     MAX_SIZE   = 3'($clog2(WIDTH / 8));
    localparam logic [WIDTH:0] REGION_END = {1'b0, BASE} + ((WIDTH + 1)'(SLAVES) << SEL_LSB);

    state_t              state_q, state_d;
    logic                hreadyout_q, hreadyout_d;
    logic [1:0]          hresp_q, hresp_d;
    logic [WIDTH-1:0]    hrdata_q, hrdata_d;
    logic [SLAVES-1:0]   psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [WIDTH-1:0]    paddr_q, paddr_d;
    logic [WIDTH-1:0]    pwdata_q, pwdata_d;
    logic [WIDTH-1:0]    addr_q, addr_d;
    logic                write_q, write_d;
    logic [SLAVES-1:0]   sel_q, sel_d;

    logic                valid;
    logic                in_range;
    logic                size_ok;
    logic [WIDTH-1:0]    offset;
    logic [WIDTH-1:0]    slot;
    logic [SLAVES-1:0]   sel_dec;
    logic                apb_err;
    logic                unused_htrans0;

    assign unused_htrans0 = Htrans[0];

`ifdef AHB2APB_PSLVERR_EN
    assign apb_err = Pslverr;
`else
    assign apb_err = 1'b0;
`endif

    // Address-phase decode; only meaningful on the edge that accepts a transfer.
    always_comb begin
        valid    = Hreadyin && Htrans[1] && hreadyout_q;
        in_range = (Haddr >= BASE) && ({1'b0, Haddr} < REGION_END);
        size_ok  = (Hsize <= MAX_SIZE);
        offset   = Haddr - BASE;
        slot     = offset >> SEL_LSB;
        sel_dec  = '0;
        for (int i = 0; i < SLAVES; i++) begin
            sel_dec[i] = (slot == WIDTH'(i));
        end
    end

    always_comb begin
        state_d     = state_q;
        hreadyout_d = hreadyout_q;
        hresp_d     = hresp_q;
        hrdata_d    = hrdata_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        addr_d      = addr_q;
        write_d     = write_q;
        sel_d       = sel_q;
        case (state_q)
            // ERR2 drives Hreadyout=1, so it accepts a new transfer exactly like IDLE.
            S_IDLE, S_ERR2: begin
                state_d     = S_IDLE;
                hreadyout_d = 1'b1;
                hresp_d     = RESP_OKAY;
                if (valid) begin
                    hreadyout_d = 1'b0;
                    if (in_range && size_ok) begin
                        state_d = S_LATCH;
                        addr_d  = Haddr;
                        write_d = Hwrite;
                        sel_d   = sel_dec;
                    end else begin
                        state_d = S_ERR1;
                        hresp_d = RESP_ERROR;
                    end
                end
            end
            S_LATCH: begin
                state_d   = S_SETUP;
                pwdata_d  = Hwdata;
                psel_d    = sel_q;
                paddr_d   = addr_q;
                pwrite_d  = write_q;
                penable_d = 1'b0;
            end
            S_SETUP: begin
                state_d   = S_ACCESS;
                penable_d = 1'b1;
            end
            S_ACCESS: begin
                if (Pready) begin
                    psel_d    = '0;
                    penable_d = 1'b0;
                    if (apb_err) begin
                        state_d = S_ERR1;
                        hresp_d = RESP_ERROR;
                    end else begin
                        state_d     = S_IDLE;
                        hreadyout_d = 1'b1;
                        hresp_d     = RESP_OKAY;
                        if (!pwrite_q) begin
                            hrdata_d = Prdata;
                        end
                    end
                end
            end
            S_ERR1: begin
                state_d     = S_ERR2;
                hresp_d     = RESP_ERROR;
                hreadyout_d = 1'b1;
            end
            default: begin
                state_d     = S_IDLE;
                hreadyout_d = 1'b1;
                hresp_d     = RESP_OKAY;
            end
        endcase
    end

    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            state_q     <= S_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= RESP_OKAY;
            hrdata_q    <= '0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            addr_q      <= '0;
            write_q     <= 1'b0;
            sel_q       <= '0;
        end else begin
            state_q     <= state_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            hrdata_q    <= hrdata_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            sel_q       <= sel_d;
        end
    end

    assign Hreadyout = hreadyout_q;
    assign Hresp     = hresp_q;
    assign Hrdata    = hrdata_q;
    assign Pselx     = psel_q;
    assign Penable   = penable_q;
    assign Pwrite    = pwrite_q;
    assign Paddr     = paddr_q;
    assign Pwdata    = pwdata_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ahb_apb_bridge_mp.sv
// Bench for ahb_apb_bridge_mp: directed scenarios plus randomized transfers checked against
// a transfer-level model (outcome, stall length, APB select and data per transfer).
module tb_ahb_apb_bridge_mp;
  localparam logic [31:0] BASE   = 32'h8000_0000;
  localparam int          SLAVES = 4;
  localparam int          WIN    = 4096;

  logic        clk = 1'b0;
  logic        hreset;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic        hreadyin;
  logic        hwrite;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic [1:0]  hresp;
  logic        hreadyout;
  logic [31:0] prdata;
  logic        pready;
`ifdef AHB2APB_PSLVERR_EN
  logic        pslverr;
`endif
  logic [3:0]  pselx;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] hrdata_model;

  // Per-transfer observation: stall cycles, ERROR cycles, APB select/enable activity and data.
  typedef struct packed {
    logic        tmo;
    logic        unstable;
    logic [7:0]  low;
    logic [7:0]  errc;
    logic [3:0]  psel;
    logic [7:0]  pselc;
    logic [7:0]  penc;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] hrdata;
  } xfer_t;

  always #5 clk = ~clk;

  ahb_apb_bridge_mp dut (
    .Hclk      (clk),
    .Hreset    (hreset),
    .Htrans    (htrans),
    .Hsize     (hsize),
    .Hreadyin  (hreadyin),
    .Hwrite    (hwrite),
    .Haddr     (haddr),
    .Hwdata    (hwdata),
    .Hrdata    (hrdata),
    .Hresp     (hresp),
    .Hreadyout (hreadyout),
    .Prdata    (prdata),
    .Pready    (pready),
`ifdef AHB2APB_PSLVERR_EN
    .Pslverr   (pslverr),
`endif
    .Pselx     (pselx),
    .Penable   (penable),
    .Pwrite    (pwrite),
    .Paddr     (paddr),
    .Pwdata    (pwdata),
    .dbg_state (dbg_state)
  );

  // Expected outcome of one transfer, from the bridge's documented rules.
  function automatic xfer_t model(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                                  input logic [31:0] wdata, input logic [31:0] rdata,
                                  input int nwait, input logic serr);
    xfer_t e;
    int slot;
    e = '0;
    e.hrdata = hrdata_model;
    if (addr < BASE || (addr - BASE) >= SLAVES * WIN || size > 3'd2) begin
      e.low  = 8'd1;
      e.errc = 8'd2;
      return e;
    end
    slot     = int'((addr - BASE) / WIN);
    e.psel   = 4'(1 << slot);
    e.pselc  = 8'(2 + nwait);
    e.penc   = 8'(1 + nwait);
    e.paddr  = addr;
    e.pwrite = wr;
    e.pwdata = wdata;
    if (serr) begin
      e.low  = 8'(4 + nwait);
      e.errc = 8'd2;
    end else begin
      e.low = 8'(3 + nwait);
      if (!wr) e.hrdata = rdata;
    end
    return e;
  endfunction

  // Presents one NONSEQ transfer at the current negedge and observes it to its Hreadyout=1 completion cycle.
  task automatic run_xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int nwait, input logic serr, output xfer_t obs);
    int waits;
    int cyc;
    obs = '0;
    waits = 0;
    cyc = 0;
    htrans = 2'b10; haddr = addr; hwrite = wr; hsize = size; hreadyin = 1'b1;
    @(posedge clk); #1;
    htrans = 2'b00; hwdata = wdata;
    haddr = $urandom; hwrite = 1'($urandom_range(0, 1));
    forever begin
      @(negedge clk);
      if (!hreadyout) obs.low++;
      if (hresp == 2'b01) obs.errc++;
      if (pselx != 4'b0) begin
        if (obs.pselc != 0 && pselx != obs.psel) obs.unstable = 1'b1;
        if ($countones(pselx) != 1) obs.unstable = 1'b1;
        obs.psel |= pselx;
        obs.pselc++;
      end
      if (penable) begin
        if (obs.penc == 0) begin
          obs.paddr = paddr; obs.pwrite = pwrite; obs.pwdata = pwdata;
        end else if (paddr != obs.paddr || pwrite != obs.pwrite || pwdata != obs.pwdata) begin
          obs.unstable = 1'b1;
        end
        obs.penc++;
      end
      if (penable && pselx != 4'b0) begin
        if (waits < nwait) begin
          pready = 1'b0;
          prdata = $urandom;
          waits++;
        end else begin
          pready = 1'b1;
          prdata = rdata;
`ifdef AHB2APB_PSLVERR_EN
          pslverr = serr;
`endif
        end
      end else begin
        pready = 1'($urandom_range(0, 1));
        prdata = $urandom;
`ifdef AHB2APB_PSLVERR_EN
        pslverr = 1'($urandom_range(0, 1));
`endif
      end
      if (hreadyout) begin
        obs.hrdata = hrdata;
        break;
      end
      cyc++;
      if (cyc > 60) begin
        obs.tmo = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    hreset = 1'b1; htrans = 2'b00; hsize = 3'd2; hreadyin = 1'b1; hwrite = 1'b0;
    haddr = '0; hwdata = '0; prdata = '0; pready = 1'b0;
`ifdef AHB2APB_PSLVERR_EN
    pslverr = 1'b0;
`endif
    repeat (3) @(negedge clk);
    n_checks++;
    if (hreadyout !== 1'b1 || hresp !== 2'b00)
      $display("FAIL reset_ahb: hreadyout=%b hresp=%b want 1/00", hreadyout, hresp);
    else n_pass++;
    n_checks++;
    if (hrdata !== 32'h0) $display("FAIL reset_hrdata: got %h want 0", hrdata);
    else n_pass++;
    n_checks++;
    if (pselx !== 4'b0 || penable !== 1'b0 || pwrite !== 1'b0)
      $display("FAIL reset_apb_ctl: pselx=%b penable=%b pwrite=%b want 0", pselx, penable, pwrite);
    else n_pass++;
    n_checks++;
    if (paddr !== 32'h0 || pwdata !== 32'h0)
      $display("FAIL reset_apb_data: paddr=%h pwdata=%h want 0", paddr, pwdata);
    else n_pass++;
    hreset = 1'b0;
    hrdata_model = '0;
    @(negedge clk);
  endtask

  task automatic test_write_basic();
    xfer_t obs, exp;
    exp = model(1'b1, 32'h8000_1004, 3'd2, 32'hA5A5_0001, 32'h0, 0, 1'b0);
    run_xfer(1'b1, 32'h8000_1004, 3'd2, 32'hA5A5_0001, 32'h0, 0, 1'b0, obs);
    n_checks++;
    if (obs !== exp)
      $display("FAIL write_basic: got low=%0d err=%0d psel=%b pwdata=%h tmo=%b want low=%0d err=%0d psel=%b pwdata=%h",
               obs.low, obs.errc, obs.psel, obs.pwdata, obs.tmo, exp.low, exp.errc, exp.psel, exp.pwdata);
    else n_pass++;
    n_checks++;
    if (obs.psel !== 4'b0010 || obs.low !== 8'd3)
      $display("FAIL write_basic_sel: got psel=%b low=%0d want 0010/3", obs.psel, obs.low);
    else n_pass++;
    hrdata_model = exp.hrdata;
  endtask

  task automatic test_read_wait();
    xfer_t obs, exp;
    exp = model(1'b0, 32'h8000_3000, 3'd2, 32'h0BAD_0BAD, 32'h1234_5678, 2, 1'b0);
    run_xfer(1'b0, 32'h8000_3000, 3'd2, 32'h0BAD_0BAD, 32'h1234_5678, 2, 1'b0, obs);
    n_checks++;
    if (obs !== exp)
      $display("FAIL read_wait: got low=%0d penc=%0d psel=%b hrdata=%h unst=%b want low=%0d penc=%0d psel=%b hrdata=%h",
               obs.low, obs.penc, obs.psel, obs.hrdata, obs.unstable, exp.low, exp.penc, exp.psel, exp.hrdata);
    else n_pass++;
    n_checks++;
    if (obs.hrdata !== 32'h1234_5678 || obs.low !== 8'd5 || obs.penc !== 8'd3)
      $display("FAIL read_wait_values: got hrdata=%h low=%0d penc=%0d want 12345678/5/3",
               obs.hrdata, obs.low, obs.penc);
    else n_pass++;
    hrdata_model = exp.hrdata;
  endtask

  task automatic test_errors();
    xfer_t obs, exp;
    exp = model(1'b1, 32'h8000_4000, 3'd2, 32'h1111_2222, 32'h0, 0, 1'b0);
    run_xfer(1'b1, 32'h8000_4000, 3'd2, 32'h1111_2222, 32'h0, 0, 1'b0, obs);
    n_checks++;
    if (obs !== exp)
      $display("FAIL err_range: got low=%0d err=%0d psel=%b want low=%0d err=%0d psel=%b",
               obs.low, obs.errc, obs.psel, exp.low, exp.errc, exp.psel);
    else n_pass++;
    exp = model(1'b0, 32'h8000_0000, 3'd3, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);
    run_xfer(1'b0, 32'h8000_0000, 3'd3, 32'h0, 32'hDEAD_BEEF, 0, 1'b0, obs);
    n_checks++;
    if (obs !== exp)
      $display("FAIL err_size: got low=%0d err=%0d psel=%b hrdata=%h want low=%0d err=%0d psel=%b hrdata=%h",
               obs.low, obs.errc, obs.psel, obs.hrdata, exp.low, exp.errc, exp.psel, exp.hrdata);
    else n_pass++;
    n_checks++;
    if (hresp !== 2'b01) $display("FAIL err_size_resp_last: got hresp=%b want 01", hresp);
    else n_pass++;
  endtask

  task automatic test_ignored();
    htrans = 2'b10; hreadyin = 1'b0; haddr = 32'h8000_0010; hwrite = 1'b1;
    @(negedge clk);
    htrans = 2'b01; hreadyin = 1'b1;
    @(negedge clk);
    htrans = 2'b00;
    @(negedge clk);
    n_checks++;
    if (pselx !== 4'b0 || hreadyout !== 1'b1 || hresp !== 2'b00)
      $display("FAIL ignored: got pselx=%b hreadyout=%b hresp=%b want 0000/1/00", pselx, hreadyout, hresp);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic        wr_t[4]   = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] addr_t[4] = '{32'h7FFF_FFFC, 32'h8000_0FFC, 32'h8000_2000, 32'h8000_3FFC};
    logic [2:0]  size_t[4] = '{3'd2, 3'd1, 3'd2, 3'd0};
    xfer_t obs, exp;
    for (int i = 0; i < 4; i++) begin
      exp = model(wr_t[i], addr_t[i], size_t[i], 32'hC0DE_0000 + i, 32'h5A5A_0000 + i, i, 1'b0);
      run_xfer(wr_t[i], addr_t[i], size_t[i], 32'hC0DE_0000 + i, 32'h5A5A_0000 + i, i, 1'b0, obs);
      n_checks++;
      if (obs !== exp)
        $display("FAIL back_to_back[%0d]: got low=%0d err=%0d psel=%b hrdata=%h want low=%0d err=%0d psel=%b hrdata=%h",
                 i, obs.low, obs.errc, obs.psel, obs.hrdata, exp.low, exp.errc, exp.psel, exp.hrdata);
      else n_pass++;
      hrdata_model = exp.hrdata;
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    xfer_t obs, exp;
    seen = 1'b0;
    pready = 1'b0;
    htrans = 2'b10; haddr = 32'h8000_2008; hwrite = 1'b1; hsize = 3'd2; hreadyin = 1'b1;
    @(posedge clk); #1;
    htrans = 2'b00; hwdata = 32'hFEED_0001;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (penable) seen = 1'b1;
    end
    n_checks++;
    if (!seen) $display("FAIL rst_mid_reach_access: penable=%b want 1 within 10 cycles", penable);
    else n_pass++;
    hreset = 1'b1;
    #1;
    n_checks++;
    if (pselx !== 4'b0 || penable !== 1'b0 || hreadyout !== 1'b1 || hrdata !== 32'h0)
      $display("FAIL rst_mid_async: got pselx=%b penable=%b hreadyout=%b hrdata=%h want 0/0/1/0",
               pselx, penable, hreadyout, hrdata);
    else n_pass++;
    @(negedge clk);
    hreset = 1'b0;
    hrdata_model = '0;
    @(negedge clk);
    exp = model(1'b0, 32'h8000_2008, 3'd2, 32'h0, 32'h600D_F00D, 1, 1'b0);
    run_xfer(1'b0, 32'h8000_2008, 3'd2, 32'h0, 32'h600D_F00D, 1, 1'b0, obs);
    n_checks++;
    if (obs !== exp)
      $display("FAIL rst_mid_next: got low=%0d psel=%b hrdata=%h want low=%0d psel=%b hrdata=%h",
               obs.low, obs.psel, obs.hrdata, exp.low, exp.psel, exp.hrdata);
    else n_pass++;
    hrdata_model = exp.hrdata;
  endtask

`ifdef AHB2APB_PSLVERR_EN
  task automatic test_pslverr();
    xfer_t obs, exp;
    exp = model(1'b0, 32'h8000_0100, 3'd2, 32'h0, 32'h7777_8888, 1, 1'b1);
    run_xfer(1'b0, 32'h8000_0100, 3'd2, 32'h0, 32'h7777_8888, 1, 1'b1, obs);
    n_checks++;
    if (obs !== exp)
      $display("FAIL pslverr: got low=%0d err=%0d hrdata=%h want low=%0d err=%0d hrdata=%h",
               obs.low, obs.errc, obs.hrdata, exp.low, exp.errc, exp.hrdata);
    else n_pass++;
    hrdata_model = exp.hrdata;
  endtask
`endif

  task automatic test_random();
    xfer_t obs, exp;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          nwait;
    logic        serr;
    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0:       addr = $urandom;
        1:       addr = BASE + SLAVES * WIN + 4 * $urandom_range(0, 255);
        2:       addr = BASE - 4 * $urandom_range(1, 8);
        default: addr = BASE + $urandom_range(0, SLAVES - 1) * WIN + 4 * $urandom_range(0, 1023);
      endcase
      size  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      wdata = $urandom;
      rdata = $urandom;
      nwait = $urandom_range(0, 3);
`ifdef AHB2APB_PSLVERR_EN
      serr = ($urandom_range(0, 4) == 0);
`else
      serr = 1'b0;
`endif
      exp = model(wr, addr, size, wdata, rdata, nwait, serr);
      run_xfer(wr, addr, size, wdata, rdata, nwait, serr, obs);
      n_checks++;
      if (obs !== exp)
        $display("FAIL random[%0d] addr=%h sz=%0d wr=%b: got low=%0d err=%0d psel=%b hrdata=%h pwdata=%h want low=%0d err=%0d psel=%b hrdata=%h pwdata=%h",
                 i, addr, size, wr, obs.low, obs.errc, obs.psel, obs.hrdata, obs.pwdata,
                 exp.low, exp.errc, exp.psel, exp.hrdata, exp.pwdata);
      else n_pass++;
      hrdata_model = exp.hrdata;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_wait();
    test_errors();
    test_ignored();
    test_back_to_back();
    test_reset_mid();
`ifdef AHB2APB_PSLVERR_EN
    test_pslverr();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule
